// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    F_REQ  = 2'd0,
    F_HELD = 2'd1,
    F_KILL = 2'd2
  } fstate_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the EX load and the ID source operands.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit_s = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu        = ex_is_load & (ex_rd != REG_X0) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fetch handshake FSM with hold buffer,
// stall/flush priority logic and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = pipe_ctrl_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_data,
  output logic [XLEN-1:0]  if_instr,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             mem_access,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fstate_e          state_r, next_state_s;
  logic [XLEN-1:0]  ibuf_r, tgt_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             ibuf_we_s, tgt_we_s, flush_inc_s;
  logic             lu_s, dstall_s;

  hazard_detect u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .lu         (lu_s)
  );

  assign dstall_s  = mem_access & ~dmem_ack;
  assign dmem_req  = mem_access;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // State, hold buffer, kill target and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= F_REQ;
      ibuf_r      <= {XLEN{1'b0}};
      tgt_r       <= {XLEN{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (ibuf_we_s) ibuf_r <= imem_data;
      if (tgt_we_s)  tgt_r  <= ex_target;
      if (!pc_we)      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_inc_s) flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Priority: data stall > taken redirect > load-use > fetch empty
  always_comb begin
    next_state_s = state_r;
    ibuf_we_s    = 1'b0;
    tgt_we_s     = 1'b0;
    flush_inc_s  = 1'b0;
    imem_req     = (state_r != F_HELD);
    if_instr     = (state_r == F_HELD) ? ibuf_r : imem_data;
    redirect_pc  = tgt_r;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_we      = 1'b0;
    idex_flush   = 1'b0;
    exmem_we     = 1'b0;
    memwb_we     = 1'b0;

    if (dstall_s) begin
      case (state_r)
        F_REQ: begin
          if (imem_ack) begin
            ibuf_we_s    = 1'b1;
            next_state_s = F_HELD;
          end else begin
            next_state_s = F_REQ;
          end
        end
        F_KILL: begin
          if (imem_ack) begin
            pc_we        = 1'b1;
            pc_sel       = 1'b1;
            next_state_s = F_REQ;
          end else begin
            next_state_s = F_KILL;
          end
        end
        default: next_state_s = state_r;
      endcase
    end else if (ex_taken && (state_r != F_KILL)) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      flush_inc_s = 1'b1;
      redirect_pc = ex_target;
      if ((state_r == F_HELD) || imem_ack) begin
        pc_we        = 1'b1;
        pc_sel       = 1'b1;
        next_state_s = F_REQ;
      end else begin
        tgt_we_s     = 1'b1;
        next_state_s = F_KILL;
      end
    end else if (state_r == F_KILL) begin
      // Wrong-path fetch outstanding: front end stays bubbled until it drains
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      if (imem_ack) begin
        pc_we        = 1'b1;
        pc_sel       = 1'b1;
        next_state_s = F_REQ;
      end else begin
        next_state_s = F_KILL;
      end
    end else if (lu_s) begin
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
      if ((state_r == F_REQ) && imem_ack) begin
        ibuf_we_s    = 1'b1;
        next_state_s = F_HELD;
      end else begin
        next_state_s = state_r;
      end
    end else begin
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
      if ((state_r == F_HELD) || imem_ack) begin
        ifid_we      = 1'b1;
        pc_we        = 1'b1;
        next_state_s = F_REQ;
      end else begin
        ifid_flush   = 1'b1;
        next_state_s = F_REQ;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: inputs change on the falling
// edge, combinational outputs are sampled 1 ns later.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_data, if_instr;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_taken;
  logic [31:0] ex_target, redirect_pc;
  logic        mem_access, dmem_ack, dmem_req, pc_we, pc_sel;
  logic        ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
  logic [31:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_data(imem_data), .if_instr(if_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_taken(ex_taken), .ex_target(ex_target),
    .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .pc_we(pc_we), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ack = 1'b0;  imem_data = 32'h0;
    id_rs1 = 5'd0;    id_rs2 = 5'd0;  id_use_rs1 = 1'b0;  id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_rd = 5'd0;  ex_taken = 1'b0;    ex_target = 32'h0;
    mem_access = 1'b0; dmem_ack = 1'b0;
  endtask

  // Next falling edge, idle inputs, optional fetch ack with data
  task automatic next_cycle(input logic ack, input logic [31:0] data);
    @(negedge clk);
    idle_inputs();
    imem_ack  = ack;
    imem_data = data;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    check_val("rst_imem_req", {31'd0, imem_req}, 32'd1);
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", flush_cnt, 32'd0);

    // Streaming fetch, no hazards
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) next_cycle(1'b1, 32'h1000 + i);
      else begin imem_ack = 1'b1; imem_data = 32'h1000; end
      #1;
      check_val("stream_pc_we", {31'd0, pc_we}, 32'd1);
      check_val("stream_if_instr", if_instr, 32'h1000 + i);
    end
    next_cycle(1'b1, 32'h2000);
    #1;
    check_val("stream_stall_cnt", stall_cnt, 32'd0);

    // Load-use on rs1: one bubble, arriving fetch parked in the hold buffer
    next_cycle(1'b1, 32'h0000_000A);
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd7;
    #1;
    check_val("lu_pc_we", {31'd0, pc_we}, 32'd0);
    check_val("lu_ifid_we", {31'd0, ifid_we}, 32'd0);
    check_val("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    check_val("lu_exmem_we", {31'd0, exmem_we}, 32'd1);
    next_cycle(1'b0, 32'h0);
    #1;
    check_val("lu_after_pc_we", {31'd0, pc_we}, 32'd1);
    check_val("lu_after_if_instr", if_instr, 32'h0000_000A);
    check_val("lu_after_ifid_we", {31'd0, ifid_we}, 32'd1);
    check_val("lu_imem_req_held", {31'd0, imem_req}, 32'd0);
    check_val("lu_stall_cnt", stall_cnt, 32'd1);

    // Load to x0 never stalls
    next_cycle(1'b1, 32'h0000_000B);
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    check_val("x0_pc_we", {31'd0, pc_we}, 32'd1);
    check_val("x0_idex_flush", {31'd0, idex_flush}, 32'd0);

    // Taken branch with fetch ack in the same cycle
    next_cycle(1'b1, 32'h0000_0BAD);
    ex_taken = 1'b1; ex_target = 32'h100;
    #1;
    check_val("tk_pc_we", {31'd0, pc_we}, 32'd1);
    check_val("tk_pc_sel", {31'd0, pc_sel}, 32'd1);
    check_val("tk_redirect", redirect_pc, 32'h100);
    check_val("tk_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check_val("tk_idex_flush", {31'd0, idex_flush}, 32'd1);
    next_cycle(1'b1, 32'h0000_0100);
    #1;
    check_val("tk_flush_cnt", flush_cnt, 32'd1);
    check_val("tk_next_pc_sel", {31'd0, pc_sel}, 32'd0);

    // Taken branch with the fetch still outstanding: kill the wrong-path word
    next_cycle(1'b0, 32'h0);
    ex_taken = 1'b1; ex_target = 32'h200;
    #1;
    check_val("kill_pc_we", {31'd0, pc_we}, 32'd0);
    check_val("kill_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(1'b0, 32'h0);
      #1;
      check_val("kill_imem_req", {31'd0, imem_req}, 32'd1);
      check_val("kill_wait_flush", {31'd0, ifid_flush}, 32'd1);
      check_val("kill_wait_pc_we", {31'd0, pc_we}, 32'd0);
      check_val("kill_wait_redirect", redirect_pc, 32'h200);
    end
    next_cycle(1'b1, 32'hDEAD_BEEF);
    #1;
    check_val("kill_ack_pc_we", {31'd0, pc_we}, 32'd1);
    check_val("kill_ack_pc_sel", {31'd0, pc_sel}, 32'd1);
    check_val("kill_ack_redirect", redirect_pc, 32'h200);
    check_val("kill_ack_ifid_we", {31'd0, ifid_we}, 32'd0);
    check_val("kill_ack_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    next_cycle(1'b1, 32'h0000_0055);
    #1;
    check_val("kill_resume_instr", if_instr, 32'h0000_0055);
    check_val("kill_resume_ifid_we", {31'd0, ifid_we}, 32'd1);
    check_val("kill_flush_cnt", flush_cnt, 32'd2);
    check_val("kill_stall_cnt", stall_cnt, 32'd5);

    // Data-memory wait: fetch ack captured into the hold buffer meanwhile
    for (int i = 0; i < 4; i++) begin
      next_cycle(i == 0, (i == 0) ? 32'h0000_0077 : 32'h0);
      mem_access = 1'b1;
      #1;
      check_val("ds_pc_we", {31'd0, pc_we}, 32'd0);
      check_val("ds_we_any", {26'd0, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}, 32'd0);
      check_val("ds_dmem_req", {31'd0, dmem_req}, 32'd1);
    end
    next_cycle(1'b0, 32'h0);
    mem_access = 1'b1; dmem_ack = 1'b1;
    #1;
    check_val("ds_done_if_instr", if_instr, 32'h0000_0077);
    check_val("ds_done_ifid_we", {31'd0, ifid_we}, 32'd1);
    check_val("ds_done_memwb_we", {31'd0, memwb_we}, 32'd1);
    check_val("ds_stall_cnt", stall_cnt, 32'd9);

    // Reset asserted while a wrong-path fetch is outstanding
    next_cycle(1'b0, 32'h0);
    ex_taken = 1'b1; ex_target = 32'h300;
    next_cycle(1'b0, 32'h0);
    #1;
    check_val("rk_redirect", redirect_pc, 32'h300);
    reset = 1'b1;
    #1;
    check_val("rk_imem_req", {31'd0, imem_req}, 32'd1);
    check_val("rk_tgt_q", redirect_pc, 32'h0);
    check_val("rk_stall_cnt", stall_cnt, 32'd0);
    check_val("rk_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    imem_ack = 1'b1; imem_data = 32'h0000_0099;
    #1;
    check_val("rk_resume_pc_sel", {31'd0, pc_sel}, 32'd0);
    check_val("rk_resume_pc_we", {31'd0, pc_we}, 32'd1);
    check_val("rk_resume_instr", if_instr, 32'h0000_0099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
